// File: rtl/feature_map_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : feature_map_arbiter
// Brief    : Single-port feature-map store shared by one reader and one
//            writer. A one-entry write buffer lets a read and a write
//            complete in the same cycle without a second memory port.
// Options  : ARBITER_FORWARD_EN - a read that hits the buffered write is
//            served from the buffer instead of stalling one drain cycle.
// Revision : 1.0 - initial release
// ============================================================================
module feature_map_arbiter #(
    parameter int BITS_PER_COORDINATE = 8,
    parameter int OUT_CHANNELS        = 4,
    parameter int BITS_PER_NEURON     = 9,
    parameter int IMG_WIDTH           = 32,
    parameter int IMG_HEIGHT          = 32
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [2*BITS_PER_COORDINATE-1:0]        coord_get,
    input  logic                                    read_req,
    output logic [OUT_CHANNELS*BITS_PER_NEURON-1:0] data_out,
    output logic                                    read_valid,
    input  logic [2*BITS_PER_COORDINATE-1:0]        coord_wtr,
    input  logic [OUT_CHANNELS*BITS_PER_NEURON-1:0] data_in,
    input  logic                                    write_req,
    output logic                                    busy
);

    localparam int C_CW    = 2 * BITS_PER_COORDINATE;
    localparam int C_DW    = OUT_CHANNELS * BITS_PER_NEURON;
    localparam int C_DEPTH = IMG_WIDTH * IMG_HEIGHT;
    localparam int C_AW    = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
`ifdef ARBITER_FORWARD_EN
    localparam bit C_FWD   = 1'b1;
`else
    localparam bit C_FWD   = 1'b0;
`endif

    function automatic logic in_range(input logic [C_CW-1:0] c);
        return (32'(c[C_CW-1:BITS_PER_COORDINATE]) < 32'(IMG_WIDTH)) &&
               (32'(c[BITS_PER_COORDINATE-1:0]) < 32'(IMG_HEIGHT));
    endfunction

    function automatic logic [C_AW-1:0] addr_of(input logic [C_CW-1:0] c);
        return C_AW'(32'(c[BITS_PER_COORDINATE-1:0]) * 32'(IMG_WIDTH) +
                      32'(c[C_CW-1:BITS_PER_COORDINATE]));
    endfunction

    // Storage and registered state
    logic [C_DW-1:0] mem_q [C_DEPTH];
    logic [C_DW-1:0] mem_rdata_q;

    logic            wbuf_valid_q, wbuf_valid_d;
    logic [C_CW-1:0] wbuf_coord_q, wbuf_coord_d;
    logic [C_DW-1:0] wbuf_data_q,  wbuf_data_d;
    logic            read_valid_q, read_valid_d;
    logic            rd_from_mem_q, rd_from_mem_d;
    logic [C_DW-1:0] bypass_q,     bypass_d;
    logic [C_DW-1:0] hold_q;

    logic            w_rd_in;
    logic            w_wr_in;
    logic            w_hit;
    logic            w_busy;
    logic            w_drain;
    logic            w_load;
    logic            w_mem_we;
    logic            w_mem_re;
    logic [C_AW-1:0] w_mem_addr;
    logic [C_DW-1:0] w_mem_wdata;

    assign w_rd_in = in_range(coord_get);
    assign w_wr_in = in_range(coord_wtr);
    assign w_hit   = wbuf_valid_q && (coord_get == wbuf_coord_q);
    assign w_busy  = wbuf_valid_q && read_req && (write_req || (!C_FWD && w_hit));

    // One memory access per cycle: either a read, a direct write, or a drain.
    always_comb begin
        w_mem_we      = 1'b0;
        w_mem_re      = 1'b0;
        w_mem_addr    = '0;
        w_mem_wdata   = '0;
        w_drain       = 1'b0;
        w_load        = 1'b0;
        wbuf_valid_d  = wbuf_valid_q;
        wbuf_coord_d  = wbuf_coord_q;
        wbuf_data_d   = wbuf_data_q;
        read_valid_d  = 1'b0;
        rd_from_mem_d = 1'b0;
        bypass_d      = '0;

        if (w_busy) begin
            w_drain = 1'b1;
        end else if (wbuf_valid_q) begin
            if (read_req) begin
                read_valid_d = 1'b1;
                if (C_FWD && w_hit) begin
                    bypass_d = wbuf_data_q;
                    w_drain  = 1'b1;
                end else if (w_rd_in) begin
                    w_mem_re      = 1'b1;
                    w_mem_addr    = addr_of(coord_get);
                    rd_from_mem_d = 1'b1;
                end
            end else if (write_req) begin
                // Out-of-range writes leave the buffer untouched.
                if (w_wr_in) begin
                    w_drain = 1'b1;
                    w_load  = 1'b1;
                end
            end else begin
                w_drain = 1'b1;
            end
        end else begin
            if (read_req) begin
                read_valid_d = 1'b1;
                if (w_rd_in) begin
                    w_mem_re      = 1'b1;
                    w_mem_addr    = addr_of(coord_get);
                    rd_from_mem_d = 1'b1;
                end
                w_load = write_req && w_wr_in;
            end else if (write_req && w_wr_in) begin
                w_mem_we    = 1'b1;
                w_mem_addr  = addr_of(coord_wtr);
                w_mem_wdata = data_in;
            end
        end

        if (w_drain) begin
            w_mem_we     = 1'b1;
            w_mem_addr   = addr_of(wbuf_coord_q);
            w_mem_wdata  = wbuf_data_q;
            wbuf_valid_d = 1'b0;
        end
        if (w_load) begin
            wbuf_valid_d = 1'b1;
            wbuf_coord_d = coord_wtr;
            wbuf_data_d  = data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbuf_valid_q  <= 1'b0;
            wbuf_coord_q  <= '0;
            wbuf_data_q   <= '0;
            read_valid_q  <= 1'b0;
            rd_from_mem_q <= 1'b0;
            bypass_q      <= '0;
            hold_q        <= '0;
        end else begin
            wbuf_valid_q  <= wbuf_valid_d;
            wbuf_coord_q  <= wbuf_coord_d;
            wbuf_data_q   <= wbuf_data_d;
            read_valid_q  <= read_valid_d;
            rd_from_mem_q <= rd_from_mem_d;
            bypass_q      <= bypass_d;
            if (read_valid_q) begin
                hold_q <= data_out;
            end
        end
    end

    // Contents survive reset; only the read data register is written on reads.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_mem_addr] <= w_mem_wdata;
        end
        if (w_mem_re) begin
            mem_rdata_q <= mem_q[w_mem_addr];
        end
    end

    assign data_out   = read_valid_q ? (rd_from_mem_q ? mem_rdata_q : bypass_q) : hold_q;
    assign read_valid = read_valid_q;
    assign busy       = w_busy;

endmodule
`default_nettype wire

// File: doc/feature_map_arbiter.md
FEATURE_MAP_ARBITER -- requirements
Module: feature_map_arbiter

Interface
REQ-001 Parameter BITS_PER_COORDINATE, default 8, width of each x/y coordinate field.
REQ-002 Parameter OUT_CHANNELS, default 4, neurons stored per coordinate.
REQ-003 Parameter BITS_PER_NEURON, default 9, signed width of one neuron state.
REQ-004 Parameter IMG_WIDTH, default 32, feature-map width; valid x is 0..IMG_WIDTH-1.
REQ-005 Parameter IMG_HEIGHT, default 32, feature-map height; valid y is 0..IMG_HEIGHT-1.
REQ-006 Port clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 Port rst_n  in  1  asynchronous, active-low reset.
REQ-008 Port coord_get  in  2*BITS_PER_COORDINATE  read coordinate {x,y}, x in the upper field.
REQ-009 Port read_req  in  1  read request.
REQ-010 Port data_out  out  OUT_CHANNELS*BITS_PER_NEURON  read data, channel 0 in the LSBs.
REQ-011 Port read_valid  out  1  one-cycle pulse marking new data_out.
REQ-012 Port coord_wtr  in  2*BITS_PER_COORDINATE  write coordinate {x,y}.
REQ-013 Port data_in  in  OUT_CHANNELS*BITS_PER_NEURON  write data.
REQ-014 Port write_req  in  1  write request.
REQ-015 Port busy  out  1  combinational stall; requests in a busy cycle are not accepted and the client holds req, coord and data.
REQ-016 The read/write port set is the arbiter side of arbiter_if, plus read_valid and busy.

Function
REQ-017 Internal single-port memory holds IMG_WIDTH*IMG_HEIGHT words of OUT_CHANNELS*BITS_PER_NEURON bits at address y*IMG_WIDTH+x, with at most one access per cycle and a synchronous read.
REQ-018 Read accepted in cycle N (read_req=1, busy=0) gives data_out at N+1 with read_valid=1 for exactly that cycle; data_out holds until the next read completes.
REQ-019 One-entry write buffer (wbuf_valid, wbuf_coord, wbuf_data).
REQ-020 Buffer empty, write only: write goes straight to memory in the same cycle.
REQ-021 Buffer empty, read and write in the same cycle: memory serves the read and the write enters the buffer.
REQ-021a In that case, if the coordinates are equal, the read returns the pre-write memory value.
REQ-022 Buffer full, write only: the buffer drains to memory and the new write enters the buffer (buffer stays full).
REQ-023 Buffer full, no request: the buffer drains and wbuf_valid clears.
REQ-024 Buffer full, read only, coordinate differs from wbuf_coord: memory serves the read and the buffer is retained.
REQ-025 busy = wbuf_valid AND read_req AND (write_req OR forwarding-disabled coordinate hit).
REQ-025a In a busy cycle the buffer drains and no request is accepted.
REQ-026 Out-of-range write (x>=IMG_WIDTH or y>=IMG_HEIGHT) is accepted and discarded with no memory or buffer change.
REQ-026a Out-of-range read returns all-zero data_out with read_valid asserted.
REQ-027 Maximum sustained rate is one access per cycle; no request is silently dropped while busy=0.

Reset
REQ-028 While rst_n=0: wbuf_valid=0, read_valid=0, data_out=0, and busy=0 follows from the cleared buffer.
REQ-028a Memory contents are not reset.
REQ-029 Reset asserted mid-operation discards any buffered write and any in-flight read; no read_valid pulse follows reset release.
REQ-029a The first request is accepted in the first clock edge with rst_n=1.

Configuration
REQ-030 Macro ARBITER_FORWARD_EN defined: a read hitting wbuf_coord with buffer full and no write is accepted without busy.
REQ-030a That read returns wbuf_data at N+1, and the buffer drains in the same cycle.
REQ-031 Macro ARBITER_FORWARD_EN undefined: that hit asserts busy for one cycle while the buffer drains.
REQ-031a The held read is then served from memory in the following cycle.

Verification
REQ-032 Write (3,5)=0x0AB..., idle, read (3,5) -> read_valid at N+1, data_out equals the written value, busy never high.
REQ-033 Buffer empty, same-cycle read and write of (1,1) with memory 0x00 and write 0x155 -> data_out=0x00; a later read returns 0x155.
REQ-034 Buffer full, write (2,0) and read (4,4) in the same cycle -> busy=1 for one cycle, then both accepted, two writes in memory.
REQ-035 Buffer holds (7,7)=V, read (7,7) only -> ARBITER_FORWARD_EN: V at N+1 with busy 0; without it: busy 1 cycle, V at N+2.
REQ-036 Write (40,0) then read (40,0) with IMG_WIDTH=32 -> no memory change, data_out=0, read_valid=1.
REQ-037 Assert rst_n low while the buffer is full -> wbuf_valid=0 and read_valid=0; after release a read of that coordinate returns the old memory value.
